rf_read_arbiter: RTL and testbench

- Shares the warp register file's two operand read ports (port 1 = rs1, port 2 = rs2) among NUM_REQ operand collectors.
- Each collector presents one read transaction: warp id, rs1/rs2 addresses and enables. The arbiter grants round-robin and sequences the register-file handshake.
- On completion it pulses a per-requester response once all enabled operands have returned.
- Operand data (32 lanes x 32 bit per port) goes straight from the register file to the collectors; this block routes control only.

---
 rtl/rf_read_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_rf_read_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
//   Shares the register file's two operand read ports (port 1 = rs1, port 2 = rs2) among
//   NUM_REQ operand collectors. Grants round-robin, issues one read strobe per enabled
//   port, waits for the data-valid returns and pulses a per-requester response. Operand
//   data bypasses this block; only control is routed here.
//
// Optional feature: define RF_READ_TIMEOUT_EN to build a WAIT watchdog. After
//   TIMEOUT_CYCLES cycles in WAIT without completion, o_err and o_rsp_valid[g] pulse
//   together and the FSM returns to IDLE. Undefined: o_err is tied 0 and WAIT is unbounded.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid           per-requester transaction request
//   o_req_ready           one-hot, one-cycle accept pulse (combinational in IDLE)
//   i_req_warp_id         per-requester warp id, 5 bits each
//   i_req_rs1_addr        per-requester rs1 address, 5 bits each
//   i_req_rs2_addr        per-requester rs2 address, 5 bits each
//   i_req_rs1_en          per-requester rs1 needed
//   i_req_rs2_en          per-requester rs2 needed
//   o_rf_warp_id          warp id to the register file (held between transactions)
//   o_rf_addr_1/2         port addresses (held between transactions)
//   o_rf_req_1/2          one-cycle read strobes
//   i_rf_data_valid_1/2   port data returned
//   o_rsp_valid           one-hot, one-cycle completion pulse
//   o_rsp_id              index of the current or last grant
//   o_busy                high in any state other than IDLE
//   o_err                 watchdog timeout pulse (optional feature)

module rf_read_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REQ_ID_W       = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*5-1:0]  i_req_warp_id,
  input  logic [NUM_REQ*5-1:0]  i_req_rs1_addr,
  input  logic [NUM_REQ*5-1:0]  i_req_rs2_addr,
  input  logic [NUM_REQ-1:0]    i_req_rs1_en,
  input  logic [NUM_REQ-1:0]    i_req_rs2_en,
  output logic [4:0]            o_rf_warp_id,
  output logic [4:0]            o_rf_addr_1,
  output logic                  o_rf_req_1,
  output logic [4:0]            o_rf_addr_2,
  output logic                  o_rf_req_2,
  input  logic                  i_rf_data_valid_1,
  input  logic                  i_rf_data_valid_2,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [REQ_ID_W-1:0]   o_rsp_id,
  output logic                  o_busy,
  output logic                  o_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                r_state;
  logic [REQ_ID_W-1:0]   r_last_grant;
  logic [REQ_ID_W-1:0]   r_rsp_id;
  logic [4:0]            r_warp_id;
  logic [4:0]            r_addr_1;
  logic [4:0]            r_addr_2;
  logic                  r_en_1;
  logic                  r_en_2;
  logic                  r_got_1;
  logic                  r_got_2;
  logic                  r_rf_req_1;
  logic                  r_rf_req_2;
  logic [NUM_REQ-1:0]    r_rsp_valid;

  logic                  w_grant_found;
  logic [REQ_ID_W-1:0]   w_grant_idx;
  logic [4:0]            w_sel_warp;
  logic [4:0]            w_sel_addr_1;
  logic [4:0]            w_sel_addr_2;
  logic                  w_sel_en_1;
  logic                  w_sel_en_2;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic [NUM_REQ-1:0]    w_rsp_onehot;
  logic                  w_got_1_n;
  logic                  w_got_2_n;
  logic                  w_wait_done;
  logic                  w_timeout;

  // Round-robin search: first requester strictly after the last grant, wrapping.
  always_comb begin
    int unsigned idx;
    logic [REQ_ID_W-1:0] cand;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    idx           = 0;
    cand          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = 32'(r_last_grant) + 32'(i) + 32'd1;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = REQ_ID_W'(idx);
      if (!w_grant_found && i_req_valid[cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = cand;
      end
    end
  end

  // Field mux for the selected requester.
  always_comb begin
    w_sel_warp   = '0;
    w_sel_addr_1 = '0;
    w_sel_addr_2 = '0;
    w_sel_en_1   = 1'b0;
    w_sel_en_2   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == REQ_ID_W'(i)) begin
        w_sel_warp   = i_req_warp_id[i*5 +: 5];
        w_sel_addr_1 = i_req_rs1_addr[i*5 +: 5];
        w_sel_addr_2 = i_req_rs2_addr[i*5 +: 5];
        w_sel_en_1   = i_req_rs1_en[i];
        w_sel_en_2   = i_req_rs2_en[i];
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == StIdle && w_grant_found) w_req_ready[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) w_rsp_onehot[i] = (r_rsp_id == REQ_ID_W'(i));
  end

  // A valid on a disabled port never sets its flag; same-cycle valids count toward done.
  assign w_got_1_n   = r_got_1 | (r_en_1 & i_rf_data_valid_1);
  assign w_got_2_n   = r_got_2 | (r_en_2 & i_rf_data_valid_2);
  assign w_wait_done = (w_got_1_n | ~r_en_1) & (w_got_2_n | ~r_en_2);

`ifdef RF_READ_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_err;

  assign w_timeout = (r_state == StWait) && !w_wait_done &&
                     (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == StIssue) r_tmo_cnt <= '0;
      else if (r_state == StWait) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_last_grant <= REQ_ID_W'(NUM_REQ - 1);
      r_rsp_id     <= '0;
      r_warp_id    <= '0;
      r_addr_1     <= '0;
      r_addr_2     <= '0;
      r_en_1       <= 1'b0;
      r_en_2       <= 1'b0;
      r_got_1      <= 1'b0;
      r_got_2      <= 1'b0;
      r_rf_req_1   <= 1'b0;
      r_rf_req_2   <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      r_rf_req_1  <= 1'b0;
      r_rf_req_2  <= 1'b0;
      r_rsp_valid <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_found) begin
            r_last_grant <= w_grant_idx;
            r_rsp_id     <= w_grant_idx;
            r_warp_id    <= w_sel_warp;
            r_addr_1     <= w_sel_addr_1;
            r_addr_2     <= w_sel_addr_2;
            r_en_1       <= w_sel_en_1;
            r_en_2       <= w_sel_en_2;
            // Strobes are registered so they appear exactly in the ISSUE cycle.
            r_rf_req_1   <= w_sel_en_1;
            r_rf_req_2   <= w_sel_en_2;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          if (!r_en_1 && !r_en_2) begin
            r_rsp_valid <= w_rsp_onehot;
            r_state     <= StResp;
          end else begin
            r_state <= StWait;
          end
        end
        StWait: begin
          r_got_1 <= w_got_1_n;
          r_got_2 <= w_got_2_n;
          if (w_wait_done) begin
            r_rsp_valid <= w_rsp_onehot;
            r_state     <= StResp;
          end else if (w_timeout) begin
            r_rsp_valid <= w_rsp_onehot;
            r_got_1     <= 1'b0;
            r_got_2     <= 1'b0;
            r_state     <= StIdle;
          end
        end
        StResp: begin
          r_got_1 <= 1'b0;
          r_got_2 <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_rf_warp_id = r_warp_id;
  assign o_rf_addr_1  = r_addr_1;
  assign o_rf_addr_2  = r_addr_2;
  assign o_rf_req_1   = r_rf_req_1;
  assign o_rf_req_2   = r_rf_req_2;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb_rf_read_arbiter
//   Directed bench for rf_read_arbiter (NUM_REQ = 4). Inputs are driven 1 time unit after
//   the rising edge and outputs are sampled there too, away from the active edge.

module tb_rf_read_arbiter;

  localparam int unsigned NReq = 4;

  logic              i_clk;
  logic              i_rst;
  logic [NReq-1:0]   i_req_valid;
  logic [NReq-1:0]   o_req_ready;
  logic [NReq*5-1:0] i_req_warp_id;
  logic [NReq*5-1:0] i_req_rs1_addr;
  logic [NReq*5-1:0] i_req_rs2_addr;
  logic [NReq-1:0]   i_req_rs1_en;
  logic [NReq-1:0]   i_req_rs2_en;
  logic [4:0]        o_rf_warp_id;
  logic [4:0]        o_rf_addr_1;
  logic              o_rf_req_1;
  logic [4:0]        o_rf_addr_2;
  logic              o_rf_req_2;
  logic              i_rf_data_valid_1;
  logic              i_rf_data_valid_2;
  logic [NReq-1:0]   o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic              o_busy;
  logic              o_err;

  int n_checks;
  int n_errors;

  rf_read_arbiter #(
    .NUM_REQ        (NReq),
    .REQ_ID_W       (2),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_warp_id     (i_req_warp_id),
    .i_req_rs1_addr    (i_req_rs1_addr),
    .i_req_rs2_addr    (i_req_rs2_addr),
    .i_req_rs1_en      (i_req_rs1_en),
    .i_req_rs2_en      (i_req_rs2_en),
    .o_rf_warp_id      (o_rf_warp_id),
    .o_rf_addr_1       (o_rf_addr_1),
    .o_rf_req_1        (o_rf_req_1),
    .o_rf_addr_2       (o_rf_addr_2),
    .o_rf_req_2        (o_rf_req_2),
    .i_rf_data_valid_1 (i_rf_data_valid_1),
    .i_rf_data_valid_2 (i_rf_data_valid_2),
    .o_rsp_valid       (o_rsp_valid),
    .o_rsp_id          (o_rsp_id),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int g, input logic [4:0] w, input logic [4:0] a1,
                         input logic [4:0] a2, input logic e1, input logic e2);
    i_req_warp_id[g*5 +: 5]  = w;
    i_req_rs1_addr[g*5 +: 5] = a1;
    i_req_rs2_addr[g*5 +: 5] = a2;
    i_req_rs1_en[g]          = e1;
    i_req_rs2_en[g]          = e2;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int g;
    n_checks          = 0;
    n_errors          = 0;
    i_rst             = 1'b1;
    i_req_valid       = '0;
    i_req_warp_id     = '0;
    i_req_rs1_addr    = '0;
    i_req_rs2_addr    = '0;
    i_req_rs1_en      = '0;
    i_req_rs2_en      = '0;
    i_rf_data_valid_1 = 1'b0;
    i_rf_data_valid_2 = 1'b0;

    // Reset values.
    tick();
    tick();
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_rsp_id", 32'(o_rsp_id), 32'd0);
    check_eq("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("rst_rf_req", {30'd0, o_rf_req_1, o_rf_req_2}, 32'd0);
    check_eq("rst_addr", {17'd0, o_rf_warp_id, o_rf_addr_1, o_rf_addr_2}, 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b0;

    // Single request from requester 0.
    set_req(0, 5'd3, 5'd5, 5'd7, 1'b1, 1'b1);
    i_req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = '0;
    check_eq("t1_rf_req", {30'd0, o_rf_req_1, o_rf_req_2}, 32'h3);
    check_eq("t1_warp", 32'(o_rf_warp_id), 32'd3);
    check_eq("t1_addr1", 32'(o_rf_addr_1), 32'd5);
    check_eq("t1_addr2", 32'(o_rf_addr_2), 32'd7);
    check_eq("t1_busy", 32'(o_busy), 32'd1);
    tick();
    check_eq("t1_strobe_once", {30'd0, o_rf_req_1, o_rf_req_2}, 32'd0);
    tick();
    i_rf_data_valid_1 = 1'b1;
    i_rf_data_valid_2 = 1'b1;
    check_eq("t1_no_early_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    i_rf_data_valid_1 = 1'b0;
    i_rf_data_valid_2 = 1'b0;
    check_eq("t1_rsp_valid", 32'(o_rsp_valid), 32'h1);
    check_eq("t1_rsp_id", 32'(o_rsp_id), 32'd0);
    tick();
    check_eq("t1_rsp_pulse", 32'(o_rsp_valid), 32'd0);
    check_eq("t1_idle", 32'(o_busy), 32'd0);
    check_eq("t1_addr_hold", 32'(o_rf_addr_1), 32'd5);

    // Round-robin with all four requesting and immediate returns.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 5'(1 + i), 5'(20 + i), 1'b1, 1'b1);
    i_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = exp_order[k];
      #1;
      check_eq($sformatf("rr%0d_ready", k), 32'(o_req_ready), 32'd1 << g);
      tick();
      check_eq($sformatf("rr%0d_no_ready", k), 32'(o_req_ready), 32'd0);
      check_eq($sformatf("rr%0d_addr1", k), 32'(o_rf_addr_1), 32'(1 + g));
      check_eq($sformatf("rr%0d_warp", k), 32'(o_rf_warp_id), 32'(10 + g));
      tick();
      i_rf_data_valid_1 = 1'b1;
      i_rf_data_valid_2 = 1'b1;
      tick();
      i_rf_data_valid_1 = 1'b0;
      i_rf_data_valid_2 = 1'b0;
      check_eq($sformatf("rr%0d_rsp", k), 32'(o_rsp_valid), 32'd1 << g);
      check_eq($sformatf("rr%0d_id", k), 32'(o_rsp_id), 32'(g));
      tick();
    end
    i_req_valid = '0;

    // Split return: valid_2 one cycle after the strobe, valid_1 five cycles after.
    set_req(1, 5'd4, 5'd9, 5'd11, 1'b1, 1'b1);
    i_req_valid = 4'b0010;
    #1;
    check_eq("split_ready", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = '0;
    tick();
    i_rf_data_valid_2 = 1'b1;
    tick();
    i_rf_data_valid_2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("split_wait%0d", i), 32'(o_rsp_valid), 32'd0);
      tick();
    end
    i_rf_data_valid_1 = 1'b1;
    check_eq("split_wait3", 32'(o_rsp_valid), 32'd0);
    tick();
    i_rf_data_valid_1 = 1'b0;
    check_eq("split_rsp", 32'(o_rsp_valid), 32'h2);
    tick();

    // Stray valid_2 while rs2 is disabled must not complete the transaction.
    set_req(1, 5'd4, 5'd9, 5'd11, 1'b1, 1'b0);
    i_req_valid = 4'b0010;
    #1;
    check_eq("stray_ready", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = '0;
    check_eq("stray_rf_req", {30'd0, o_rf_req_1, o_rf_req_2}, 32'h2);
    tick();
    i_rf_data_valid_2 = 1'b1;
    tick();
    i_rf_data_valid_2 = 1'b0;
    check_eq("stray_no_early", 32'(o_rsp_valid), 32'd0);
    check_eq("stray_busy", 32'(o_busy), 32'd1);
    i_rf_data_valid_1 = 1'b1;
    tick();
    i_rf_data_valid_1 = 1'b0;
    check_eq("stray_rsp", 32'(o_rsp_valid), 32'h2);
    tick();

    // No operands on requester 2: no strobes, response two cycles after accept.
    set_req(2, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    i_req_valid = 4'b0100;
    #1;
    check_eq("noop_ready", 32'(o_req_ready), 32'h4);
    tick();
    i_req_valid = '0;
    check_eq("noop_rf_req", {30'd0, o_rf_req_1, o_rf_req_2}, 32'd0);
    check_eq("noop_busy", 32'(o_busy), 32'd1);
    tick();
    check_eq("noop_rsp", 32'(o_rsp_valid), 32'h4);
    check_eq("noop_id", 32'(o_rsp_id), 32'd2);
    tick();

    // Reset while in WAIT.
    set_req(2, 5'd8, 5'd3, 5'd4, 1'b1, 1'b0);
    i_req_valid = 4'b0100;
    #1;
    check_eq("rw_ready", 32'(o_req_ready), 32'h4);
    tick();
    i_req_valid = '0;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_eq("rw_busy", 32'(o_busy), 32'd0);
    check_eq("rw_rsp_id", 32'(o_rsp_id), 32'd0);
    check_eq("rw_addr", {17'd0, o_rf_warp_id, o_rf_addr_1, o_rf_addr_2}, 32'd0);
    check_eq("rw_rsp_valid", 32'(o_rsp_valid), 32'd0);
    i_rf_data_valid_1 = 1'b1;
    tick();
    i_rf_data_valid_1 = 1'b0;
    check_eq("rw_stray_rsp", 32'(o_rsp_valid), 32'd0);
    check_eq("rw_stray_busy", 32'(o_busy), 32'd0);
    tick();
    check_eq("rw_stray_rsp2", 32'(o_rsp_valid), 32'd0);
    i_req_valid = 4'b1111;
    #1;
    check_eq("rw_first_grant", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = '0;
    tick();
    i_rf_data_valid_1 = 1'b1;
    i_rf_data_valid_2 = 1'b1;
    tick();
    i_rf_data_valid_1 = 1'b0;
    i_rf_data_valid_2 = 1'b0;
    check_eq("rw_rsp0", 32'(o_rsp_valid), 32'h1);
    tick();

`ifdef RF_READ_TIMEOUT_EN
    // Watchdog: valid_1 never returns.
    set_req(1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
    i_req_valid = 4'b0010;
    #1;
    check_eq("tmo_ready", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("tmo_wait%0d", i), {30'd0, o_err, o_busy}, 32'h1);
    end
    tick();
    check_eq("tmo_err", 32'(o_err), 32'd1);
    check_eq("tmo_rsp", 32'(o_rsp_valid), 32'h2);
    check_eq("tmo_idle", 32'(o_busy), 32'd0);
    tick();
    check_eq("tmo_err_pulse", 32'(o_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
